// File: rtl/rob_param_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : rob_pkg
//  Brief    : Shared types and default geometry for the reorder buffer.
//  Revision : 1.0  - initial parametrised release
// ============================================================================
package rob_pkg;

   // Default geometry; the entry struct below is laid out with these widths
   localparam int DEF_DEPTH      = 32;
   localparam int DEF_DISPATCH_W = 3;
   localparam int DEF_COMMIT_W   = 3;
   localparam int DEF_WB_PORTS   = 3;
   localparam int DEF_PREG_W     = 5;
   localparam int DEF_AREG_W     = 3;
   localparam int DEF_TYPE_W     = 2;

   // Instruction class carried in each entry
   typedef enum logic [DEF_TYPE_W-1:0] {
      TYPE_ALU   = 2'b00,
      TYPE_MUL   = 2'b01,
      TYPE_LOAD  = 2'b10,
      TYPE_STORE = 2'b11
   } rob_type_e;

   // One buffer entry at the default widths
   typedef struct packed {
      logic                  ready;
      logic                  excep;
      logic [DEF_TYPE_W-1:0] itype;
      logic [DEF_PREG_W-1:0] pw;
      logic [DEF_PREG_W-1:0] pw_old;
      logic [DEF_AREG_W-1:0] rw;
   } rob_entry_t;

endpackage
`default_nettype wire

// File: rtl/rob_param_if.sv
`default_nettype none
// ============================================================================
//  Module   : rob_param_if
//  Brief    : Dispatch, writeback, commit and status bundle of the ROB.
//  Revision : 1.0  - initial parametrised release
// ============================================================================
interface rob_param_if
   import rob_pkg::*;
#(
   parameter int DEPTH      = DEF_DEPTH,
   parameter int DISPATCH_W = DEF_DISPATCH_W,
   parameter int COMMIT_W   = DEF_COMMIT_W,
   parameter int WB_PORTS   = DEF_WB_PORTS,
   parameter int PREG_W     = DEF_PREG_W,
   parameter int AREG_W     = DEF_AREG_W,
   parameter int TYPE_W     = DEF_TYPE_W
);
   localparam int TAG_W = $clog2(DEPTH);

   logic                                  flush;
   logic [DISPATCH_W-1:0]                 disp_valid;
   logic [DISPATCH_W-1:0][TYPE_W-1:0]     disp_type;
   logic [DISPATCH_W-1:0][PREG_W-1:0]     disp_pw;
   logic [DISPATCH_W-1:0][PREG_W-1:0]     disp_pw_old;
   logic [DISPATCH_W-1:0][AREG_W-1:0]     disp_rw;
   logic [DISPATCH_W-1:0]                 disp_excep;
   logic                                  disp_ready;
   logic [DISPATCH_W-1:0][TAG_W-1:0]      disp_tag;

   logic [WB_PORTS-1:0]                   wb_valid;
   logic [WB_PORTS-1:0][TAG_W-1:0]        wb_tag;
   logic [WB_PORTS-1:0]                   wb_excep;

   logic [COMMIT_W-1:0]                   commit_valid;
   logic [COMMIT_W-1:0][TYPE_W-1:0]       commit_type;
   logic [COMMIT_W-1:0][PREG_W-1:0]       commit_pw;
   logic [COMMIT_W-1:0][PREG_W-1:0]       commit_pw_old;
   logic [COMMIT_W-1:0][AREG_W-1:0]       commit_rw;

   logic                                  excep_valid;
   logic [TAG_W-1:0]                      excep_tag;
   logic [TAG_W-1:0]                      head_tag;
   logic [TAG_W:0]                        count;
   logic                                  empty;

   // Pipeline side (rename/dispatch, execute, commit consumer)
   modport master (
      output flush, disp_valid, disp_type, disp_pw, disp_pw_old, disp_rw, disp_excep,
      output wb_valid, wb_tag, wb_excep,
      input  disp_ready, disp_tag,
      input  commit_valid, commit_type, commit_pw, commit_pw_old, commit_rw,
      input  excep_valid, excep_tag, head_tag, count, empty
   );

   // Reorder buffer side
   modport slave (
      input  flush, disp_valid, disp_type, disp_pw, disp_pw_old, disp_rw, disp_excep,
      input  wb_valid, wb_tag, wb_excep,
      output disp_ready, disp_tag,
      output commit_valid, commit_type, commit_pw, commit_pw_old, commit_rw,
      output excep_valid, excep_tag, head_tag, count, empty
   );

endinterface
`default_nettype wire

// File: rtl/rob_param_commit_sel.sv
`default_nettype none
// ============================================================================
//  Module   : rob_commit_sel
//  Brief    : In-order retire prefix selector over a window of entries.
//             Slot k retires only if slots 0..k are valid, ready and clean.
//  Revision : 1.0  - initial release
// ============================================================================
module rob_commit_sel #(
   parameter int WIDTH = 3,
   parameter int CNT_W = $clog2(WIDTH + 1)
)(
   input  logic [WIDTH-1:0] valid,
   input  logic [WIDTH-1:0] ready,
   input  logic [WIDTH-1:0] excep,
   output logic [WIDTH-1:0] mask,
   output logic [CNT_W-1:0] n_c,
   output logic             head_excep
);

   // Walk the window oldest-first; the first blocked slot ends the prefix
   always_comb begin
      logic run;
      run  = 1'b1;
      mask = '0;
      n_c  = '0;
      for (int k = 0; k < WIDTH; k++) begin
         run     = run & valid[k] & ready[k] & ~excep[k];
         mask[k] = run;
         if (run) begin
            n_c = n_c + CNT_W'(1);
         end
      end
   end

   // A completed excepting entry at the head is reported instead of retiring
   assign head_excep = valid[0] & ready[0] & excep[0];

endmodule
`default_nettype wire

// File: rtl/rob_param.sv
`default_nettype none
// ============================================================================
//  Module   : rob_param
//  Brief    : Parametrised reorder buffer. Allocates in program order,
//             collects completions from WB_PORTS writeback ports, retires up
//             to COMMIT_W entries per cycle and reports a precise exception
//             at the head.
//  Revision : 1.0  - initial parametrised release
// ============================================================================
module rob_param
   import rob_pkg::*;
#(
   parameter int DEPTH      = DEF_DEPTH,
   parameter int DISPATCH_W = DEF_DISPATCH_W,
   parameter int COMMIT_W   = DEF_COMMIT_W,
   parameter int WB_PORTS   = DEF_WB_PORTS,
   parameter int PREG_W     = DEF_PREG_W,
   parameter int AREG_W     = DEF_AREG_W,
   parameter int TYPE_W     = DEF_TYPE_W
)(
   input  logic       clk,
   input  logic       rst,
   rob_param_if.slave bus
);

   localparam int TAG_W = $clog2(DEPTH);
   localparam int CNT_W = TAG_W + 1;
   localparam int ND_W  = $clog2(DISPATCH_W + 1);
   localparam int NC_W  = $clog2(COMMIT_W + 1);

   typedef struct packed {
      logic [TYPE_W-1:0] itype;
      logic [PREG_W-1:0] pw;
      logic [PREG_W-1:0] pw_old;
      logic [AREG_W-1:0] rw;
   } payload_t;

   // Per-entry status and payload storage
   logic [DEPTH-1:0]                 valid;
   logic [DEPTH-1:0]                 ready;
   logic [DEPTH-1:0]                 excep;
   payload_t                         mem [DEPTH];
   logic [TAG_W-1:0]                 head;
   logic [TAG_W-1:0]                 tail;
   logic [CNT_W-1:0]                 count;

   logic [DISPATCH_W-1:0][TAG_W-1:0] slot_tag;
   logic [ND_W-1:0]                  n_d;
   logic                             disp_ready;
   logic                             do_disp;

   logic [COMMIT_W-1:0][TAG_W-1:0]   commit_idx;
   logic [COMMIT_W-1:0]              win_valid;
   logic [COMMIT_W-1:0]              win_ready;
   logic [COMMIT_W-1:0]              win_excep;
   logic [COMMIT_W-1:0]              commit_mask;
   logic [NC_W-1:0]                  n_c;
   logic                             head_excep;

   // Space check uses only the registered count; same-cycle frees are not bypassed
   assign disp_ready = (int'(count) + DISPATCH_W) <= DEPTH;
   assign do_disp    = disp_ready & (|bus.disp_valid);

   // Slot tags follow the tail; valid is a prefix so slot i lands at tail+i
   always_comb begin
      n_d = '0;
      for (int i = 0; i < DISPATCH_W; i++) begin
         slot_tag[i] = tail + TAG_W'(i);
         n_d         = n_d + ND_W'(bus.disp_valid[i]);
      end
   end

   // Gather the retire window starting at head; indices wrap naturally mod DEPTH
   always_comb begin
      for (int k = 0; k < COMMIT_W; k++) begin
         commit_idx[k]        = head + TAG_W'(k);
         win_valid[k]         = valid[commit_idx[k]];
         win_ready[k]         = ready[commit_idx[k]];
         win_excep[k]         = excep[commit_idx[k]];
         bus.commit_type[k]   = mem[commit_idx[k]].itype;
         bus.commit_pw[k]     = mem[commit_idx[k]].pw;
         bus.commit_pw_old[k] = mem[commit_idx[k]].pw_old;
         bus.commit_rw[k]     = mem[commit_idx[k]].rw;
      end
   end

   rob_commit_sel #(
      .WIDTH      (COMMIT_W),
      .CNT_W      (NC_W)
   ) u_commit_sel (
      .valid      (win_valid),
      .ready      (win_ready),
      .excep      (win_excep),
      .mask       (commit_mask),
      .n_c        (n_c),
      .head_excep (head_excep)
   );

   assign bus.disp_ready   = disp_ready;
   assign bus.disp_tag     = slot_tag;
   assign bus.commit_valid = commit_mask;
   assign bus.excep_valid  = head_excep;
   assign bus.excep_tag    = head;
   assign bus.head_tag     = head;
   assign bus.count        = count;
   assign bus.empty        = (count == '0);

   // Status and pointers: writeback, then retire clear, then allocate; flush wins
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         valid <= '0;
         ready <= '0;
         excep <= '0;
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else if (bus.flush) begin
         valid <= '0;
         ready <= '0;
         excep <= '0;
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else begin
         for (int p = 0; p < WB_PORTS; p++) begin
            if (bus.wb_valid[p] && valid[bus.wb_tag[p]]) begin
               ready[bus.wb_tag[p]] <= 1'b1;
               if (bus.wb_excep[p]) begin
                  excep[bus.wb_tag[p]] <= 1'b1;
               end
            end
         end
         for (int k = 0; k < COMMIT_W; k++) begin
            if (commit_mask[k]) begin
               valid[commit_idx[k]] <= 1'b0;
               ready[commit_idx[k]] <= 1'b0;
               excep[commit_idx[k]] <= 1'b0;
            end
         end
         if (do_disp) begin
            for (int i = 0; i < DISPATCH_W; i++) begin
               if (bus.disp_valid[i]) begin
                  valid[slot_tag[i]] <= 1'b1;
                  ready[slot_tag[i]] <= 1'b0;
                  excep[slot_tag[i]] <= bus.disp_excep[i];
               end
            end
            tail <= tail + TAG_W'(n_d);
         end
         head  <= head + TAG_W'(n_c);
         count <= count + (do_disp ? CNT_W'(n_d) : '0) - CNT_W'(n_c);
      end
   end

   // Payload is only meaningful while valid is set, so it needs no reset
   always_ff @(posedge clk) begin
      if (do_disp && !bus.flush) begin
         for (int i = 0; i < DISPATCH_W; i++) begin
            if (bus.disp_valid[i]) begin
               mem[slot_tag[i]].itype  <= bus.disp_type[i];
               mem[slot_tag[i]].pw     <= bus.disp_pw[i];
               mem[slot_tag[i]].pw_old <= bus.disp_pw_old[i];
               mem[slot_tag[i]].rw     <= bus.disp_rw[i];
            end
         end
      end
   end

endmodule
`default_nettype wire
